// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and types for the decode-to-writeback control pipeline.
// Bundle layout puts alucontrol in the top byte so alucontrol[7] doubles as the divide marker.
package ctrl_pipe_pkg;

  localparam int CW_DEF = 13;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  localparam int BIT_MEMTOREG   = 0;
  localparam int BIT_MEMWRITE   = 1;
  localparam int BIT_ALUSRC     = 2;
  localparam int BIT_REGDST     = 3;
  localparam int BIT_REGWRITE   = 4;
  localparam int BIT_ALUCTL_LSB = 5;
  localparam int BIT_MDU_DEF    = 12;

  typedef enum logic {IDLE, BUSY} seq_state_e;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side bundle/handshake bus of the control pipeline.
interface ctrl_pipe_if #(
  parameter int CW     = 13,
  parameter int NSTAGE = 3
);
  logic [CW-1:0]        ctrlD;
  logic                 validD;
  logic [NSTAGE-1:0]    stall_i;
  logic [NSTAGE-1:0]    flush_i;
  logic [NSTAGE*CW-1:0] ctrl_o;
  logic [NSTAGE-1:0]    valid_o;
  logic                 stall_req;
  logic                 mdu_busy;
  logic                 mdu_done;

  modport master (
    output ctrlD, validD, stall_i, flush_i,
    input  ctrl_o, valid_o, stall_req, mdu_busy, mdu_done
  );

  modport slave (
    input  ctrlD, validD, stall_i, flush_i,
    output ctrl_o, valid_o, stall_req, mdu_busy, mdu_done
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control bundle plus valid, with bubble > hold > load priority.
module ctrl_stage_reg #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble_i,
  input  logic          hold_i,
  input  logic [CW-1:0] ctrl_i,
  input  logic          valid_i,
  output logic [CW-1:0] ctrl_o,
  output logic          valid_o
);
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic          valid_q, valid_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (bubble_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      ctrl_d  = ctrl_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline top: per-stage stall/flush with bubble insertion, plus the
// multicycle-divide sequencer that holds E and raises the hazard-unit stall request.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int NSTAGE     = 3,
  parameter int MDU_BIT    = BIT_MDU_DEF,
  parameter int DIV_CYCLES = 32
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);
  localparam int CNTW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [NSTAGE-1:0][CW-1:0] ctrl_q, up_ctrl;
  logic [NSTAGE-1:0]         vld_q, up_vld, st, hold;
  seq_state_e                state_q, state_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic                      stall_req_w, load_div;

  assign stall_req_w = (state_q == BUSY) && (cnt_q != '0);

  // A stage loading behind a holding upstream takes a bubble, so nothing is duplicated.
  always_comb begin
    st         = bus.stall_i;
    st[STG_E]  = bus.stall_i[STG_E] | stall_req_w;
    hold       = st & ~bus.flush_i;
    up_ctrl    = '0;
    up_vld     = '0;
    up_ctrl[0] = bus.ctrlD;
    up_vld[0]  = bus.validD;
    for (int k = 1; k < NSTAGE; k++) begin
      if (!hold[k-1]) begin
        up_ctrl[k] = ctrl_q[k-1];
        up_vld[k]  = vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    ctrl_stage_reg #(.CW(CW)) u_stg (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (bus.flush_i[k]),
      .hold_i   (hold[k]),
      .ctrl_i   (up_ctrl[k]),
      .valid_i  (up_vld[k]),
      .ctrl_o   (ctrl_q[k]),
      .valid_o  (vld_q[k])
    );
  end

  // A new divide may start on the same edge the previous one leaves E.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_div = !bus.flush_i[STG_E] && !st[STG_E] && bus.validD &&
               bus.ctrlD[MDU_BIT] && (DIV_CYCLES > 1);
    if (state_q == BUSY && bus.flush_i[STG_E]) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (load_div) begin
      state_d = BUSY;
      cnt_d   = CNTW'(DIV_CYCLES - 1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ctrl_o    = ctrl_q;
  assign bus.valid_o   = vld_q;
  assign bus.stall_req = stall_req_w;
  assign bus.mdu_busy  = (state_q == BUSY);
  assign bus.mdu_done  = (state_q == BUSY && cnt_q == '0) ||
                         (DIV_CYCLES == 1 && vld_q[STG_E] && ctrl_q[STG_E][MDU_BIT]);
endmodule
